// File: rtl/assert_logger_pkg.sv
// Shared constants and record types for the assertion event logger.
package assert_logger_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_TS_W  = 16;
    localparam int DEF_CNT_W = 8;

    // Widest timestamp a record can carry; TS_W must not exceed this.
    localparam int TS_MAX = DEF_TS_W;

    // One logged violation: the cycle at which the obligation was armed.
    typedef struct packed {
        logic [TS_MAX-1:0] ts;
    } ev_rec_t;

    // Obligation captured on a check request: the value O must match next cycle.
    typedef struct packed {
        logic    exp_o;
        ev_rec_t ev;
    } obligation_t;

endpackage

// File: rtl/assert_event_fifo.sv
// Violation log: DEPTH-entry FIFO with a valid/ready read side.
// Handshake: an entry leaves when out_valid && out_ready at a rising edge;
// out_data holds still while out_valid=1 and out_ready=0. A push on a full
// FIFO is taken only when a pop happens in the same cycle. There is no
// push-to-output bypass, so a push into an empty FIFO shows up next cycle.
module assert_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         empty;
    logic         do_pop;
    logic         do_push;

    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rptr[AW-1:0]];
    assign do_pop    = out_valid && out_ready;
    assign do_push   = push && (!full || do_pop);

    // Advance read/write pointers on accepted pops and pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: out_data is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/assert_event_logger.sv
// Checks the one-cycle property "on a qualified request, next-cycle O equals
// this-cycle I", stamps each violation with the request cycle, and logs it.
import assert_logger_pkg::*;

module assert_event_logger #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int TS_W  = DEF_TS_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             I,
    input  logic             O,
    input  logic             other,
    input  logic             check_en,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [TS_W-1:0]  ev_ts,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             overflow,
    output logic             armed
);

    logic [TS_W-1:0] ts;
    obligation_t     ob;
    logic            violation;
    logic            pop;
    logic            full;

    // A pending obligation is checked regardless of check_en, so dropping
    // the enable never cancels it, and a fresh arm in the same cycle only
    // replaces the record after this cycle's comparison has been made.
    assign violation = armed && (O != ob.exp_o);
    assign pop       = ev_valid && ev_ready;

    // Free-running cycle timestamp, wraps naturally at 2^TS_W.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) ts <= '0;
        else            ts <= ts + TS_W'(1);
    end

    // Capture I and the current timestamp on a qualified check request.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            armed <= 1'b0;
            ob    <= '0;
        end else begin
            armed <= check_en && other;
            if (check_en && other) begin
                ob.exp_o <= I;
                ob.ev.ts <= TS_MAX'(ts);
            end
        end
    end

    // Saturating count of every violation, logged or dropped.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET)                           fail_cnt <= '0;
        else if (violation && (fail_cnt != '1))   fail_cnt <= fail_cnt + CNT_W'(1);
    end

    // Sticky flag: a violation found the log full with no pop to make room.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET)                        overflow <= 1'b0;
        else if (violation && full && !pop)    overflow <= 1'b1;
    end

    assert_event_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W)
    ) u_fifo (
        .clk       (CLK),
        .rst       (ASYNCRESET),
        .push      (violation),
        .push_data (ob.ev.ts[TS_W-1:0]),
        .out_valid (ev_valid),
        .out_ready (ev_ready),
        .out_data  (ev_ts),
        .full      (full)
    );

endmodule

// File: tb/tb_assert_event_logger.sv
// Bench: two logger instances (default widths, and TS_W=4/CNT_W=2) share one
// stimulus stream and are compared every cycle against a cycle-count model.
module tb_assert_event_logger;

    localparam int DEPTH = 4;
    localparam int TS_A  = 16;
    localparam int CNT_A = 8;
    localparam int TS_B  = 4;
    localparam int CNT_B = 2;

    // ---------------- clock / reset / DUT ----------------
    logic CLK = 1'b0;
    logic ASYNCRESET = 1'b1;
    logic I = 1'b0, O = 1'b0, other = 1'b0, check_en = 1'b0, ev_ready = 1'b0;

    logic             ev_valid_a, overflow_a, armed_a;
    logic [TS_A-1:0]  ev_ts_a;
    logic [CNT_A-1:0] fail_cnt_a;
    logic             ev_valid_b, overflow_b, armed_b;
    logic [TS_B-1:0]  ev_ts_b;
    logic [CNT_B-1:0] fail_cnt_b;

    always #5 CLK = ~CLK;

    assert_event_logger #(.DEPTH(DEPTH), .TS_W(TS_A), .CNT_W(CNT_A)) dut_a (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .I(I), .O(O), .other(other),
        .check_en(check_en), .ev_valid(ev_valid_a), .ev_ready(ev_ready),
        .ev_ts(ev_ts_a), .fail_cnt(fail_cnt_a), .overflow(overflow_a), .armed(armed_a)
    );

    assert_event_logger #(.DEPTH(DEPTH), .TS_W(TS_B), .CNT_W(CNT_B)) dut_b (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .I(I), .O(O), .other(other),
        .check_en(check_en), .ev_valid(ev_valid_b), .ev_ready(ev_ready),
        .ev_ts(ev_ts_b), .fail_cnt(fail_cnt_b), .overflow(overflow_b), .armed(armed_b)
    );

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_pass   = 0;

    // Model state in plain terms: absolute cycle count, the pending request,
    // a queue of logged request cycles, total violations, overflow seen.
    int t;
    bit pend_v;
    bit pend_i;
    int pend_t;
    int exp_q[$];
    int fails;
    bit ovf;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        t      = 0;
        pend_v = 0;
        pend_i = 0;
        pend_t = 0;
        exp_q.delete();
        fails  = 0;
        ovf    = 0;
    endtask

    // One rising edge, using the inputs that were stable before it.
    task automatic model_edge();
        bit popped;
        int sz;
        sz     = exp_q.size();
        popped = (sz > 0) && (ev_ready == 1'b1);
        if (popped) void'(exp_q.pop_front());
        if (pend_v && (O != pend_i)) begin
            fails++;
            if (sz < DEPTH || popped) exp_q.push_back(pend_t);
            else                      ovf = 1;
        end
        pend_v = check_en && other;
        pend_i = I;
        pend_t = t;
        t++;
    endtask

    task automatic check_outputs(input string ph);
        check({ph, "_valid_a"}, int'(ev_valid_a), int'(exp_q.size() > 0));
        check({ph, "_valid_b"}, int'(ev_valid_b), int'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check({ph, "_ts_a"}, int'(ev_ts_a), exp_q[0] % (1 << TS_A));
            check({ph, "_ts_b"}, int'(ev_ts_b), exp_q[0] % (1 << TS_B));
        end
        check({ph, "_cnt_a"}, int'(fail_cnt_a), sat(fails, CNT_A));
        check({ph, "_cnt_b"}, int'(fail_cnt_b), sat(fails, CNT_B));
        check({ph, "_ovf_a"}, int'(overflow_a), int'(ovf));
        check({ph, "_ovf_b"}, int'(overflow_b), int'(ovf));
        check({ph, "_armed_a"}, int'(armed_a), int'(pend_v));
        check({ph, "_armed_b"}, int'(armed_b), int'(pend_v));
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; leaves the bench at the next falling edge.
    task automatic step(input logic i_v, input logic o_v, input logic oth,
                        input logic en, input logic rdy, input string ph);
        I        = i_v;
        O        = o_v;
        other    = oth;
        check_en = en;
        ev_ready = rdy;
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs(ph);
        @(negedge CLK);
    endtask

    // Mid-cycle reset pulse, released well before the next rising edge.
    task automatic do_reset(input string ph);
        ASYNCRESET = 1'b1;
        #1;
        model_reset();
        check_outputs(ph);
        check({ph, "_ts0_a"}, int'(ev_ts_a), 0);
        check({ph, "_ts0_b"}, int'(ev_ts_b), 0);
        #1;
        ASYNCRESET = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        @(negedge CLK);
        do_reset("rst0");

        // Matching output after a request: no event logged.
        step(1, 0, 1, 1, 0, "pass_arm");
        step(0, 1, 0, 1, 0, "pass_chk");
        step(0, 1, 0, 1, 0, "pass_after");
        check("pass_no_event", int'(ev_valid_a), 0);
        check("pass_cnt", int'(fail_cnt_a), 0);

        // Violation of a request made at timestamp 5.
        do_reset("rst1");
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 0, "idle");
        step(1, 0, 1, 1, 0, "ts5_arm");
        step(0, 0, 0, 1, 0, "ts5_chk");
        check("ts5_valid", int'(ev_valid_a), 1);
        check("ts5_ts", int'(ev_ts_a), 5);
        check("ts5_cnt", int'(fail_cnt_a), 1);

        // Five back-to-back violations into a 4-deep log with no consumer.
        do_reset("rst2");
        for (int k = 0; k < 6; k++) step(1, 0, (k < 5), 1, 0, "fill5");
        check("fill5_cnt", int'(fail_cnt_a), 5);
        check("fill5_ovf", int'(overflow_a), 1);
        check("fill5_head", int'(ev_ts_a), 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 1, "drain");
        check("drain_empty", int'(ev_valid_a), 0);
        step(0, 0, 0, 1, 1, "drain_idle");

        // Full log, pop and push in the same cycle: no overflow.
        do_reset("rst3");
        for (int k = 0; k < 5; k++) step(1, 0, 1, 1, 0, "fill4");
        step(1, 0, 0, 1, 1, "full_pushpop");
        check("full_pushpop_ovf", int'(overflow_a), 0);
        check("full_pushpop_cnt", int'(fail_cnt_a), 5);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1, "drain2");

        // Reset in the cycle where an obligation would fail: it is discarded.
        do_reset("rst4");
        step(1, 0, 1, 1, 1, "kill_arm");
        O = 1'b0;
        other = 1'b0;
        do_reset("kill_rst");
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 1, "kill_after");
        check("kill_no_event", int'(ev_valid_a), 0);
        check("kill_cnt", int'(fail_cnt_a), 0);

        // Continuous violations with a ready consumer: small counter
        // saturates and the short timestamp wraps.
        do_reset("rst5");
        for (int k = 0; k < 20; k++) step(1, 0, 1, 1, 1, "wrap");
        check("sat_cnt_b", int'(fail_cnt_b), 3);
        check("sat_cnt_a", int'(fail_cnt_a), 19);
        for (int k = 0; k < 2; k++) step(0, 0, 0, 1, 1, "wrap_tail");

        // Randomized traffic with occasional resets.
        do_reset("rst6");
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 79) == 0) do_reset("rnd_rst");
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 5) != 0),
                 1'($urandom_range(0, 3) == 0), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
